// File: rtl/game_report_tx.sv
// Serialises a 13-byte "L:x R:x W:x\r\n" result line to the UART TX on each rising edge of show.
// Optional stall abort is built only when GAME_REPORT_TIMEOUT_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for a show rising edge
//  SEND   | offering byte[idx] to the UART until accepted
//  DONE   | one-cycle done pulse, then back to IDLE
module game_report_tx #(
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       show,
   input  logic [3:0] hand,
   input  logic [1:0] score,
   output logic [7:0] tx_data,
   output logic       tx_data_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       timeout
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("game_report_tx: TIMEOUT_CYCLES must be at least 2");
   end

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       show_q;
   logic [3:0] hand_q, hand_d;
   logic [1:0] score_q, score_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       trigger;

`ifdef GAME_REPORT_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] STALL_LOAD = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] stall_q, stall_d;
   logic          timeout_q, timeout_d;
`endif

   function automatic logic [7:0] hand_code(input logic [1:0] h);
      case (h)
         2'd0:    hand_code = 8'h53;
         2'd1:    hand_code = 8'h52;
         2'd2:    hand_code = 8'h50;
         default: hand_code = 8'h3F;
      endcase
   endfunction

   function automatic logic [7:0] win_code(input logic [1:0] s);
      case (s)
         2'b10:   win_code = 8'h4C;
         2'b11:   win_code = 8'h52;
         default: win_code = 8'h44;
      endcase
   endfunction

   function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [3:0] h,
                                           input logic [1:0] s);
      case (i)
         4'd0:    msg_byte = 8'h4C;
         4'd1:    msg_byte = 8'h3A;
         4'd2:    msg_byte = hand_code(h[1:0]);
         4'd3:    msg_byte = 8'h20;
         4'd4:    msg_byte = 8'h52;
         4'd5:    msg_byte = 8'h3A;
         4'd6:    msg_byte = hand_code(h[3:2]);
         4'd7:    msg_byte = 8'h20;
         4'd8:    msg_byte = 8'h57;
         4'd9:    msg_byte = 8'h3A;
         4'd10:   msg_byte = win_code(s);
         4'd11:   msg_byte = 8'h0D;
         4'd12:   msg_byte = 8'h0A;
         default: msg_byte = 8'h00;
      endcase
   endfunction

   assign trigger = show & ~show_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hand_d     = hand_q;
      score_d    = score_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
`ifdef GAME_REPORT_TIMEOUT_EN
      stall_d    = stall_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d    = S_SEND;
               idx_d      = 4'd0;
               hand_d     = hand;
               score_d    = score;
               tx_valid_d = 1'b1;
               // Captured fields are not visible until the next cycle; byte 0 is a constant anyway.
               tx_data_d  = 8'h4C;
`ifdef GAME_REPORT_TIMEOUT_EN
               stall_d    = STALL_LOAD;
`endif
            end
         end
         S_SEND: begin
            if (tx_valid_q && tx_ready) begin
`ifdef GAME_REPORT_TIMEOUT_EN
               stall_d = STALL_LOAD;
`endif
               if (idx_q == 4'd12) begin
                  state_d    = S_DONE;
                  tx_valid_d = 1'b0;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = msg_byte(idx_q + 4'd1, hand_q, score_q);
               end
            end
`ifdef GAME_REPORT_TIMEOUT_EN
            else if (stall_q == '0) begin
               state_d    = S_IDLE;
               tx_valid_d = 1'b0;
               timeout_d  = 1'b1;
            end else begin
               stall_d = stall_q - CW'(1);
            end
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         show_q     <= 1'b1;
         hand_q     <= 4'd0;
         score_q    <= 2'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
`ifdef GAME_REPORT_TIMEOUT_EN
         stall_q    <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         show_q     <= show;
         hand_q     <= hand_d;
         score_q    <= score_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
`ifdef GAME_REPORT_TIMEOUT_EN
         stall_q    <= stall_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
`ifdef GAME_REPORT_TIMEOUT_EN
   assign timeout       = timeout_q;
`else
   assign timeout       = 1'b0;
`endif

endmodule
